// File: rtl/sev_seg_scan.sv
// Time-multiplexed six-digit 7-segment scanner with anti-ghost blanking,
// 16-level brightness PWM and per-digit blinking. All outputs are registered.
module sev_seg_scan #(
  parameter int unsigned SCAN_DIV    = 24999,
  parameter int unsigned BLANK_CYC   = 500,
  parameter int unsigned BLINK_DIV   = 12499999,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [5:0][6:0] seg_in,
  input  logic [5:0]      blink_mask,
  input  logic [3:0]      bright,
  output logic [6:0]      seg_out,
  output logic [5:0]      dig_sel,
  output logic            frame_tick
);

  localparam int unsigned SlotW  = $clog2(SCAN_DIV + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);

  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(SCAN_DIV);
  localparam logic [SlotW-1:0]  BlankLast = SlotW'(BLANK_CYC - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV);
  localparam logic [6:0]        SegOff    = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]        DigOff    = DIG_ACT_LOW ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e            state_q, state_d;
  logic [SlotW-1:0]  slot_cnt_q, slot_cnt_d;
  logic [2:0]        dig_idx_q, dig_idx_d;
  logic [3:0]        pwm_cnt_q, pwm_cnt_d;
  logic [6:0]        seg_hold_q, seg_hold_d;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_ph_q;
  logic [6:0]        seg_d;
  logic [5:0]        dig_d;
  logic              tick_d;
  logic              slot_end;
  logic              lit;

  assign slot_end = (state_q == StDrive) && (slot_cnt_q == SlotLast);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; a low enable always wins, including on a slot wrap
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StBlank;
        StBlank: if (slot_cnt_q == BlankLast) state_d = StDrive;
        StDrive: if (slot_end) state_d = StBlank;
        default: state_d = StIdle;
      endcase
    end
  end

  // Slot datapath
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    dig_idx_d  = dig_idx_q;
    pwm_cnt_d  = pwm_cnt_q;
    seg_hold_d = seg_hold_q;
    if (!en || state_q == StIdle) begin
      slot_cnt_d = '0;
      dig_idx_d  = '0;
      pwm_cnt_d  = '0;
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
      // Latch the pattern once per slot so mid-slot input changes cannot glitch
      if (state_q == StBlank && slot_cnt_q == '0) seg_hold_d = seg_in[dig_idx_q];
      if (state_q == StDrive) pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (slot_end) begin
        slot_cnt_d = '0;
        pwm_cnt_d  = '0;
        dig_idx_d  = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q <= '0;
      dig_idx_q  <= '0;
      pwm_cnt_q  <= '0;
      seg_hold_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      dig_idx_q  <= dig_idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
      seg_hold_q <= seg_hold_d;
    end
  end

  // Free-running blink timer, independent of enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= ~blink_ph_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Output decode; XOR against the off level applies polarity
  assign lit = (pwm_cnt_q <= bright) && !(blink_mask[dig_idx_q] && blink_ph_q);

  always_comb begin
    seg_d  = SegOff;
    dig_d  = DigOff;
    tick_d = 1'b0;
    if (en && state_q == StDrive) begin
      tick_d = slot_end && (dig_idx_q == 3'd5);
      if (lit) begin
        dig_d = DigOff ^ (6'd1 << dig_idx_q);
        seg_d = SegOff ^ seg_hold_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out    <= SegOff;
      dig_sel    <= DigOff;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_d;
      dig_sel    <= dig_d;
      frame_tick <= tick_d;
    end
  end

endmodule
